// File: rtl/wordle_pkg.sv
// rtl/wordle_pkg.sv - Shared widths, feedback codes, scorer states and slice helper for the Wordle scorer
package wordle_pkg;

  localparam int LETTER_W = 8;
  localparam int WORD_LEN = 5;

  localparam logic [1:0] FB_GRAY   = 2'b00;
  localparam logic [1:0] FB_YELLOW = 2'b01;
  localparam logic [1:0] FB_GREEN  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_DONE   = 2'd3
  } scorer_state_e;

  // Position 0 sits in the most significant slice of a packed word.
  function automatic int slice_lsb(input int pos, input int width);
    return (WORD_LEN - 1 - pos) * width;
  endfunction

endpackage

// File: rtl/wordle_guess_scorer_if.sv
// rtl/wordle_guess_scorer_if.sv - Request/response bundle between the game state machine and the scorer
interface wordle_guess_scorer_if
  import wordle_pkg::*;
  ();

  logic                         guess_valid;
  logic                         guess_ready;
  logic [WORD_LEN*LETTER_W-1:0] guess;
  logic [WORD_LEN*LETTER_W-1:0] answer;
  logic [2*WORD_LEN-1:0]        result;
  logic                         result_valid;
  logic                         win;

  modport master (
    output guess_valid, guess, answer,
    input  guess_ready, result, result_valid, win
  );

  modport slave (
    input  guess_valid, guess, answer,
    output guess_ready, result, result_valid, win
  );

endinterface

// File: rtl/wordle_match_finder.sv
// rtl/wordle_match_finder.sv - Finds the lowest answer position holding a letter that is not yet claimed
module wordle_match_finder
  import wordle_pkg::*;
(
  input  logic [LETTER_W-1:0]          letter,
  input  logic [WORD_LEN*LETTER_W-1:0] answer,
  input  logic [WORD_LEN-1:0]          used,
  output logic                         found,
  output logic [WORD_LEN-1:0]          match_onehot
);

  always_comb begin
    found        = 1'b0;
    match_onehot = '0;
    for (int j = 0; j < WORD_LEN; j++) begin
      if (!found && !used[j] && (answer[slice_lsb(j, LETTER_W) +: LETTER_W] == letter)) begin
        found           = 1'b1;
        match_onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wordle_guess_scorer.sv
// rtl/wordle_guess_scorer.sv - Wordle scorer: exact-match pass, then one guess position per cycle for misplaced letters
module wordle_guess_scorer
  import wordle_pkg::*;
(
  input  logic                 Clk,
  input  logic                 reset,
  wordle_guess_scorer_if.slave bus
);

  localparam int WORD_W = WORD_LEN * LETTER_W;
  localparam int IDX_W  = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_LEN - 1);

  scorer_state_e         state_q, state_d;
  logic [WORD_W-1:0]     guess_q, guess_d;
  logic [WORD_W-1:0]     answer_q, answer_d;
  logic [WORD_LEN-1:0]   green_q, green_d;
  logic [WORD_LEN-1:0]   used_q, used_d;
  logic [2*WORD_LEN-1:0] tag_q, tag_d;
  logic [2*WORD_LEN-1:0] result_q, result_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  result_valid_q, result_valid_d;
  logic                  win_q, win_d;

  logic [LETTER_W-1:0]   cur_letter;
  logic                  mf_found;
  logic [WORD_LEN-1:0]   mf_onehot;

  assign cur_letter = guess_q[slice_lsb(int'(idx_q), LETTER_W) +: LETTER_W];

  wordle_match_finder u_match_finder (
    .letter       (cur_letter),
    .answer       (answer_q),
    .used         (used_q),
    .found        (mf_found),
    .match_onehot (mf_onehot)
  );

  always_comb begin
    state_d        = state_q;
    guess_d        = guess_q;
    answer_d       = answer_q;
    green_d        = green_q;
    used_d         = used_q;
    tag_d          = tag_q;
    idx_d          = idx_q;
    result_d       = result_q;
    win_d          = win_q;
    result_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.guess_valid) begin
          guess_d  = bus.guess;
          answer_d = bus.answer;
          green_d  = '0;
          used_d   = '0;
          tag_d    = '0;
          state_d  = ST_GREEN;
        end
      end
      ST_GREEN: begin
        for (int i = 0; i < WORD_LEN; i++) begin
          green_d[i] = (guess_q[slice_lsb(i, LETTER_W) +: LETTER_W] ==
                        answer_q[slice_lsb(i, LETTER_W) +: LETTER_W]);
          tag_d[slice_lsb(i, 2) +: 2] = green_d[i] ? FB_GREEN : FB_GRAY;
        end
        // Greens claim their answer letters before any yellow search runs.
        used_d  = green_d;
        idx_d   = '0;
        state_d = ST_YELLOW;
      end
      ST_YELLOW: begin
        if (!green_q[idx_q]) begin
          if (mf_found) begin
            tag_d[slice_lsb(int'(idx_q), 2) +: 2] = FB_YELLOW;
            used_d = used_q | mf_onehot;
          end else begin
            tag_d[slice_lsb(int'(idx_q), 2) +: 2] = FB_GRAY;
          end
        end
        // Results load on the way into DONE so result_valid lines up with that cycle.
        if (idx_q == LAST_IDX) begin
          result_d       = tag_d;
          win_d          = &green_q;
          result_valid_d = 1'b1;
          state_d        = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      guess_q        <= '0;
      answer_q       <= '0;
      green_q        <= '0;
      used_q         <= '0;
      tag_q          <= '0;
      idx_q          <= '0;
      result_q       <= '0;
      win_q          <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      guess_q        <= guess_d;
      answer_q       <= answer_d;
      green_q        <= green_d;
      used_q         <= used_d;
      tag_q          <= tag_d;
      idx_q          <= idx_d;
      result_q       <= result_d;
      win_q          <= win_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign bus.guess_ready  = (state_q == ST_IDLE);
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.win          = win_q;

endmodule

// File: tb/tb_wordle_guess_scorer.sv
// tb/tb_wordle_guess_scorer.sv - Directed self-checking bench for the Wordle guess scorer
module tb_wordle_guess_scorer;
  import wordle_pkg::*;

  logic Clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_mis = 0;
  logic [9:0] prev_res;

  always #5 Clk = ~Clk;

  wordle_guess_scorer_if bus ();

  wordle_guess_scorer dut (
    .Clk   (Clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns just after the accepting posedge with the buses scrambled.
  task automatic accept(input string tag, input logic [39:0] g, input logic [39:0] a);
    bus.guess       = g;
    bus.answer      = a;
    bus.guess_valid = 1'b1;
    check_val({tag, "_ready_at_req"}, 32'(bus.guess_ready), 32'd1);
    @(posedge Clk);
    #1;
    bus.guess_valid = 1'b0;
    bus.guess       = ~g;
    bus.answer      = ~a;
  endtask

  task automatic wait_result(input logic [9:0] hold, input bit poke,
                             output int lat, output bit held_ok, output bit busy_ok);
    lat     = 0;
    held_ok = 1'b1;
    busy_ok = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge Clk);
      if (bus.result_valid) begin
        lat = k;
        break;
      end
      if (bus.guess_ready) busy_ok = 1'b0;
      if (bus.result !== hold) held_ok = 1'b0;
      if (poke && k == 3) begin
        bus.guess_valid = 1'b1;
        bus.guess       = "ABBEY";
      end
      if (poke && k == 4) bus.guess_valid = 1'b0;
    end
  endtask

  task automatic run_basic(input string tag, input logic [39:0] g, input logic [39:0] a,
                           input logic [9:0] exp_res, input bit exp_win, input bit poke);
    int lat;
    bit held_ok;
    bit busy_ok;
    int pulses;
    accept(tag, g, a);
    wait_result(prev_res, poke, lat, held_ok, busy_ok);
    check_val({tag, "_latency"}, 32'(lat), 32'd7);
    check_val({tag, "_result"}, 32'(bus.result), 32'(exp_res));
    check_val({tag, "_win"}, 32'(bus.win), 32'(exp_win));
    check_val({tag, "_ready_low_busy"}, 32'(busy_ok), 32'd1);
    check_val({tag, "_prev_result_held"}, 32'(held_ok), 32'd1);
    prev_res = exp_res;
    @(negedge Clk);
    check_val({tag, "_valid_one_cycle"}, 32'(bus.result_valid), 32'd0);
    check_val({tag, "_ready_back"}, 32'(bus.guess_ready), 32'd1);
    check_val({tag, "_result_hold"}, 32'(bus.result), 32'(exp_res));
    if (poke) begin
      pulses = 0;
      repeat (10) begin
        @(negedge Clk);
        if (bus.result_valid) pulses++;
      end
      check_val({tag, "_no_extra_result"}, 32'(pulses), 32'd0);
    end
  endtask

  initial begin
    int pulses;
    reset           = 1'b1;
    bus.guess_valid = 1'b0;
    bus.guess       = '0;
    bus.answer      = '0;
    prev_res        = '0;

    repeat (3) @(negedge Clk);
    check_val("rst_ready", 32'(bus.guess_ready), 32'd1);
    check_val("rst_result", 32'(bus.result), 32'd0);
    check_val("rst_valid", 32'(bus.result_valid), 32'd0);
    check_val("rst_win", 32'(bus.win), 32'd0);
    reset = 1'b0;
    @(negedge Clk);

    run_basic("crane", "CRANE", "CRANE", 10'b10_10_10_10_10, 1'b1, 1'b0);

    // Abort mid-scoring: reset sampled at the end of cycle T+4.
    accept("abort", "PAPER", "APPLE");
    repeat (4) @(negedge Clk);
    reset = 1'b1;
    @(negedge Clk);
    check_val("abort_ready", 32'(bus.guess_ready), 32'd1);
    check_val("abort_result", 32'(bus.result), 32'd0);
    check_val("abort_win", 32'(bus.win), 32'd0);
    check_val("abort_valid", 32'(bus.result_valid), 32'd0);
    reset = 1'b0;
    pulses = 0;
    repeat (10) begin
      @(negedge Clk);
      if (bus.result_valid) pulses++;
    end
    check_val("abort_no_result", 32'(pulses), 32'd0);
    prev_res = '0;

    run_basic("paper", "PAPER", "APPLE", 10'b01_01_10_01_00, 1'b0, 1'b0);
    run_basic("bobby", "BOBBY", "ABBEY", 10'b01_00_10_00_10, 1'b0, 1'b0);
    run_basic("fluid", "FLUID", "CRANE", 10'b00_00_00_00_00, 1'b0, 1'b1);

    // Back-to-back: second request issued in the T+8 IDLE cycle of the first.
    run_basic("b2b_first", "BOBBY", "ABBEY", 10'b01_00_10_00_10, 1'b0, 1'b0);
    run_basic("b2b_second", "CRANE", "CRANE", 10'b10_10_10_10_10, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
